digital_clock_core: RTL and testbench

Timekeeping and mode-control core of the digital clock; drives the display driver stage downstream. The block has four functions:
- Divides the system clock into a 1 Hz tick and keeps HH:MM:SS in packed BCD.
- Runs the time-set and alarm-set state machine from pre-debounced key pulses.
- Produces the per-digit-pair enable and twinkle controls, plus the hourly-chime and alarm levels.
- Feeds `number_BCD`, `DTube_en`, `Twinkle_en`, `HOURLY`, `ALARM` directly into the display driver.

---
 rtl/digital_clock_pkg.sv | 38 +++
 rtl/digital_clock_core_bcd_counter_2d.sv | 46 ++++
 rtl/digital_clock_core.sv | 196 +++++++++++++++++++
 tb/tb_digital_clock_core.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/digital_clock_pkg.sv
// ------------------------------------------------------------------
// digital_clock_pkg: shared state encoding, BCD limits and helpers.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

package digital_clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_H  = 3'd1,
    ST_SET_M  = 3'd2,
    ST_SET_S  = 3'd3,
    ST_SET_AH = 3'd4,
    ST_SET_AM = 3'd5
  } clk_state_e;

  localparam logic [7:0] MAX_HOUR   = 8'h23;
  localparam logic [7:0] MAX_MINSEC = 8'h59;

  localparam int PAIR_SEC  = 0;
  localparam int PAIR_MIN  = 1;
  localparam int PAIR_HOUR = 2;

  // Two-digit BCD increment with wrap from max back to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] value, input logic [7:0] max);
    if (value == max) begin
      return 8'h00;
    end else if (value[3:0] == 4'd9) begin
      return {value[7:4] + 4'd1, 4'h0};
    end else begin
      return {value[7:4], value[3:0] + 4'd1};
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/digital_clock_core_bcd_counter_2d.sv
// ------------------------------------------------------------------
// bcd_counter_2d: two-digit BCD counter wrapping at MAX, with load.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module bcd_counter_2d
  import digital_clock_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst_N,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (inc) begin
      value_d = bcd_inc(value_q, MAX);
    end
  end

  always_ff @(posedge clk or posedge rst_N) begin
    if (rst_N) begin
      value_q <= 8'h00;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc && !load && (value_q == MAX);

endmodule

`default_nettype wire

// File: rtl/digital_clock_core.sv
// ------------------------------------------------------------------
// digital_clock_core: 1 Hz prescaler, HH:MM:SS/alarm keeping, set-mode FSM
// and registered display/chime/alarm controls. Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module digital_clock_core
  import digital_clock_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int HOURLY_SEC = 5,
  parameter int ALARM_SEC  = 30
) (
  input  logic        clk,
  input  logic        rst_N,
  input  logic        key_mode,
  input  logic        key_up,
  input  logic        alarm_on,
  output logic [23:0] number_BCD,
  output logic [2:0]  DTube_en,
  output logic [2:0]  Twinkle_en,
  output logic        HOURLY,
  output logic        ALARM
);

  localparam int PRE_W  = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int HCNT_W = 4;
  localparam int ACNT_W = 6;

  logic [PRE_W-1:0]  pre_q, pre_d;
  clk_state_e        state_q, state_d;
  logic              hourly_q, hourly_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              alarm_q, alarm_d;
  logic [ACNT_W-1:0] acnt_q, acnt_d;
  logic [23:0]       disp_q, disp_d;
  logic [2:0]        dtube_q, dtube_d;
  logic [2:0]        twinkle_q, twinkle_d;
  logic              hourly_out_q, alarm_out_q;

  logic       tick, counting, count_tick, up;
  logic       sec_inc, min_inc, hour_inc, alh_inc, alm_inc;
  logic       sec_carry, min_carry, hour_carry, alh_carry, alm_carry;
  logic [7:0] sec_val, min_val, hour_val, alh_val, alm_val;
  logic [7:0] next_mm, next_hh;
  logic       hourly_trig, alarm_trig, unused_carries;

  assign tick  = (pre_q == PRE_W'(TICK_DIV - 1));
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  assign counting   = (state_q == ST_RUN) || (state_q == ST_SET_AH) || (state_q == ST_SET_AM);
  assign count_tick = tick && counting;
  // key_mode wins over a coincident key_up
  assign up         = key_up && !key_mode;

  assign sec_inc  = count_tick || (up && state_q == ST_SET_S);
  assign min_inc  = (count_tick && sec_carry) || (up && state_q == ST_SET_M);
  assign hour_inc = (count_tick && min_carry) || (up && state_q == ST_SET_H);
  assign alh_inc  = up && (state_q == ST_SET_AH);
  assign alm_inc  = up && (state_q == ST_SET_AM);

  bcd_counter_2d #(.MAX(MAX_MINSEC)) u_sec (
    .clk(clk), .rst_N(rst_N), .inc(sec_inc), .load(1'b0), .load_val(8'h00),
    .value(sec_val), .carry(sec_carry));
  bcd_counter_2d #(.MAX(MAX_MINSEC)) u_min (
    .clk(clk), .rst_N(rst_N), .inc(min_inc), .load(1'b0), .load_val(8'h00),
    .value(min_val), .carry(min_carry));
  bcd_counter_2d #(.MAX(MAX_HOUR)) u_hour (
    .clk(clk), .rst_N(rst_N), .inc(hour_inc), .load(1'b0), .load_val(8'h00),
    .value(hour_val), .carry(hour_carry));
  bcd_counter_2d #(.MAX(MAX_MINSEC)) u_alarm_min (
    .clk(clk), .rst_N(rst_N), .inc(alm_inc), .load(1'b0), .load_val(8'h00),
    .value(alm_val), .carry(alm_carry));
  bcd_counter_2d #(.MAX(MAX_HOUR)) u_alarm_hour (
    .clk(clk), .rst_N(rst_N), .inc(alh_inc), .load(1'b0), .load_val(8'h00),
    .value(alh_val), .carry(alh_carry));

  assign unused_carries = hour_carry ^ alh_carry ^ alm_carry;

  // Triggers look at the time this tick is about to produce.
  assign next_mm     = (sec_val == MAX_MINSEC) ? bcd_inc(min_val, MAX_MINSEC) : min_val;
  assign next_hh     = ((sec_val == MAX_MINSEC) && (min_val == MAX_MINSEC)) ?
                       bcd_inc(hour_val, MAX_HOUR) : hour_val;
  assign hourly_trig = count_tick && min_carry;
  assign alarm_trig  = count_tick && alarm_on && (sec_val == MAX_MINSEC) &&
                       (next_mm == alm_val) && (next_hh == alh_val);

  always_comb begin
    state_d = state_q;
    if (key_mode) begin
      case (state_q)
        ST_RUN:    state_d = ST_SET_H;
        ST_SET_H:  state_d = ST_SET_M;
        ST_SET_M:  state_d = ST_SET_S;
        ST_SET_S:  state_d = ST_SET_AH;
        ST_SET_AH: state_d = ST_SET_AM;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    hourly_d = hourly_q;
    hcnt_d   = hcnt_q;
    if (hourly_trig) begin
      hourly_d = 1'b1;
      hcnt_d   = HCNT_W'(HOURLY_SEC);
    end else if (count_tick && hourly_q) begin
      if (hcnt_q <= HCNT_W'(1)) begin
        hourly_d = 1'b0;
        hcnt_d   = '0;
      end else begin
        hcnt_d = hcnt_q - 1'b1;
      end
    end

    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (!alarm_on) begin
      alarm_d = 1'b0;
      acnt_d  = '0;
    end else if (alarm_trig) begin
      alarm_d = 1'b1;
      acnt_d  = ACNT_W'(ALARM_SEC);
    end else if (up && state_q == ST_RUN) begin
      alarm_d = 1'b0;
      acnt_d  = '0;
    end else if (count_tick && alarm_q) begin
      if (acnt_q <= ACNT_W'(1)) begin
        alarm_d = 1'b0;
        acnt_d  = '0;
      end else begin
        acnt_d = acnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    disp_d    = {hour_val, min_val, sec_val};
    dtube_d   = 3'b111;
    twinkle_d = 3'b000;
    case (state_q)
      ST_SET_H: twinkle_d[PAIR_HOUR] = 1'b1;
      ST_SET_M: twinkle_d[PAIR_MIN]  = 1'b1;
      ST_SET_S: twinkle_d[PAIR_SEC]  = 1'b1;
      ST_SET_AH: begin
        disp_d               = {alh_val, alm_val, 8'h00};
        dtube_d[PAIR_SEC]    = 1'b0;
        twinkle_d[PAIR_HOUR] = 1'b1;
      end
      ST_SET_AM: begin
        disp_d              = {alh_val, alm_val, 8'h00};
        dtube_d[PAIR_SEC]   = 1'b0;
        twinkle_d[PAIR_MIN] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst_N) begin
    if (rst_N) begin
      pre_q        <= '0;
      state_q      <= ST_RUN;
      hourly_q     <= 1'b0;
      hcnt_q       <= '0;
      alarm_q      <= 1'b0;
      acnt_q       <= '0;
      disp_q       <= 24'h000000;
      dtube_q      <= 3'b111;
      twinkle_q    <= 3'b000;
      hourly_out_q <= 1'b0;
      alarm_out_q  <= 1'b0;
    end else begin
      pre_q        <= pre_d;
      state_q      <= state_d;
      hourly_q     <= hourly_d;
      hcnt_q       <= hcnt_d;
      alarm_q      <= alarm_d;
      acnt_q       <= acnt_d;
      disp_q       <= disp_d;
      dtube_q      <= dtube_d;
      twinkle_q    <= twinkle_d;
      hourly_out_q <= hourly_q;
      alarm_out_q  <= alarm_q;
    end
  end

  assign number_BCD = disp_q;
  assign DTube_en   = dtube_q;
  assign Twinkle_en = twinkle_q;
  assign HOURLY     = hourly_out_q;
  assign ALARM      = alarm_out_q;

endmodule

`default_nettype wire

// File: tb/tb_digital_clock_core.sv
// ------------------------------------------------------------------
// tb_digital_clock_core: directed bench for digital_clock_core, TICK_DIV=4.
// Revision 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_digital_clock_core;

  logic        clk;
  logic        rst_N;
  logic        key_mode;
  logic        key_up;
  logic        alarm_on;
  logic [23:0] number_BCD;
  logic [2:0]  DTube_en;
  logic [2:0]  Twinkle_en;
  logic        HOURLY;
  logic        ALARM;

  int checks   = 0;
  int failures = 0;
  int cyc;

  digital_clock_core #(.TICK_DIV(4), .HOURLY_SEC(5), .ALARM_SEC(30)) dut (
    .clk(clk), .rst_N(rst_N), .key_mode(key_mode), .key_up(key_up),
    .alarm_on(alarm_on), .number_BCD(number_BCD), .DTube_en(DTube_en),
    .Twinkle_en(Twinkle_en), .HOURLY(HOURLY), .ALARM(ALARM));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; equals the prescaler phase, ticks land on cyc%4==0.
  always @(posedge clk or posedge rst_N) begin
    if (rst_N) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk24(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_N = 1'b1;
    key_mode = 1'b0;
    key_up = 1'b0;
    step();
    step();
    rst_N = 1'b0;
  endtask

  // Advance to the stable mid-tick sampling point (cyc%4==2).
  task automatic sync_mid();
    do step(); while (cyc % 4 != 2);
  endtask

  task automatic pulse_up(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      key_up = 1'b1;
      step();
      key_up = 1'b0;
    end
  endtask

  task automatic pulse_mode();
    step();
    key_mode = 1'b1;
    step();
    key_mode = 1'b0;
  endtask

  // key_mode held n cycles starting at a tick boundary so no tick hits the middle states.
  task automatic mode_burst(input int n);
    while (cyc % 4 != 0) step();
    key_mode = 1'b1;
    repeat (n) step();
    key_mode = 1'b0;
  endtask

  // Alarm 00:01 armed, time 00:00:58 -> RUN; returns at cyc=4k+6 showing 00:00:59.
  task automatic arm_alarm();
    do_reset();
    alarm_on = 1'b1;
    mode_burst(3);
    pulse_up(58);
    while (cyc % 4 != 0) step();
    key_mode = 1'b1;
    step();
    step();
    key_mode = 1'b0;
    key_up = 1'b1;
    step();
    key_up = 1'b0;
    key_mode = 1'b1;
    step();
    key_mode = 1'b0;
    chk24("arm_am_display", number_BCD, 24'h000100);
    chk3("arm_am_dtube", DTube_en, 3'b110);
    sync_mid();
    chk24("arm_run_time", number_BCD, 24'h000059);
    chk3("arm_run_dtube", DTube_en, 3'b111);
  endtask

  initial begin
    rst_N = 1'b1;
    key_mode = 1'b0;
    key_up = 1'b0;
    alarm_on = 1'b0;
    #12;
    chk24("reset_bcd", number_BCD, 24'h000000);
    chk3("reset_dtube", DTube_en, 3'b111);
    chk3("reset_twinkle", Twinkle_en, 3'b000);
    chk1("reset_hourly", HOURLY, 1'b0);
    chk1("reset_alarm", ALARM, 1'b0);

    // Rollover 23:59:58 -> 00:00:00 with hourly chime
    do_reset();
    mode_burst(1);
    pulse_up(23);
    mode_burst(1);
    pulse_up(59);
    mode_burst(1);
    pulse_up(58);
    sync_mid();
    chk24("roll_preset", number_BCD, 24'h235958);
    chk3("roll_tw_sets", Twinkle_en, 3'b001);
    mode_burst(3);
    sync_mid();
    chk24("roll_2359_59", number_BCD, 24'h235959);
    chk1("roll_hourly_pre", HOURLY, 1'b0);
    for (int i = 0; i < 5; i++) begin
      sync_mid();
      chk24("roll_time", number_BCD, 24'(i));
      chk1("roll_hourly_hi", HOURLY, 1'b1);
    end
    sync_mid();
    chk24("roll_time5", number_BCD, 24'h000005);
    chk1("roll_hourly_lo", HOURLY, 1'b0);
    chk1("roll_no_alarm", ALARM, 1'b0);

    // Hour edit: frozen time, 23->00 wrap, resume in RUN
    do_reset();
    mode_burst(1);
    pulse_up(22);
    sync_mid();
    chk24("edit_h22", number_BCD, 24'h220000);
    chk3("edit_tw_h", Twinkle_en, 3'b100);
    chk3("edit_dtube", DTube_en, 3'b111);
    repeat (10) sync_mid();
    chk24("edit_frozen", number_BCD, 24'h220000);
    pulse_up(3);
    sync_mid();
    chk24("edit_wrap", number_BCD, 24'h010000);
    mode_burst(2);
    mode_burst(3);
    sync_mid();
    chk24("edit_resume1", number_BCD, 24'h010001);
    chk3("edit_tw_run", Twinkle_en, 3'b000);
    sync_mid();
    chk24("edit_resume2", number_BCD, 24'h010002);

    // Alarm ring: 2-edge latency, 30 ticks, falls
    arm_alarm();
    step();
    step();
    chk1("ring_not_yet", ALARM, 1'b0);
    chk24("ring_pre_time", number_BCD, 24'h000059);
    step();
    chk1("ring_rise", ALARM, 1'b1);
    chk24("ring_time", number_BCD, 24'h000100);
    chk1("ring_no_hourly", HOURLY, 1'b0);
    for (int i = 0; i < 30; i++) begin
      sync_mid();
      chk1("ring_hold", ALARM, 1'b1);
    end
    sync_mid();
    chk1("ring_fall", ALARM, 1'b0);
    chk24("ring_end_time", number_BCD, 24'h000130);

    // Dismiss with key_up in RUN, coinciding with a tick
    arm_alarm();
    sync_mid();
    chk1("dis_ringing", ALARM, 1'b1);
    sync_mid();
    step();
    key_up = 1'b1;
    step();
    key_up = 1'b0;
    chk1("dis_still_hi", ALARM, 1'b1);
    step();
    chk1("dis_cleared", ALARM, 1'b0);
    chk24("dis_time", number_BCD, 24'h000102);
    sync_mid();
    sync_mid();
    chk24("dis_time_next", number_BCD, 24'h000103);
    chk1("dis_stays_lo", ALARM, 1'b0);

    // alarm_on falling clears a ringing alarm
    arm_alarm();
    sync_mid();
    chk1("off_ringing", ALARM, 1'b1);
    alarm_on = 1'b0;
    step();
    step();
    chk1("off_cleared", ALARM, 1'b0);

    // Simultaneous keys in SET_M, then no carry out of SET_S
    do_reset();
    mode_burst(1);
    pulse_up(10);
    mode_burst(1);
    pulse_up(59);
    sync_mid();
    chk24("sim_preset", number_BCD, 24'h105900);
    chk3("sim_tw_m", Twinkle_en, 3'b010);
    step();
    key_mode = 1'b1;
    key_up = 1'b1;
    step();
    key_mode = 1'b0;
    key_up = 1'b0;
    sync_mid();
    chk3("sim_tw_s", Twinkle_en, 3'b001);
    chk24("sim_min_kept", number_BCD, 24'h105900);
    pulse_up(59);
    sync_mid();
    chk24("sim_sec59", number_BCD, 24'h105959);
    pulse_up(1);
    sync_mid();
    chk24("sim_no_carry", number_BCD, 24'h105900);

    // Alarm-set display, then asynchronous reset mid-SET_AH
    mode_burst(1);
    sync_mid();
    chk24("ah_display", number_BCD, 24'h000000);
    chk3("ah_dtube", DTube_en, 3'b110);
    chk3("ah_tw", Twinkle_en, 3'b100);
    pulse_up(2);
    sync_mid();
    chk24("ah_hour2", number_BCD, 24'h020000);
    mode_burst(1);
    pulse_up(1);
    sync_mid();
    chk24("am_display", number_BCD, 24'h020100);
    chk3("am_tw", Twinkle_en, 3'b010);
    chk3("am_dtube", DTube_en, 3'b110);
    repeat (5) pulse_mode();
    sync_mid();
    chk3("ah_again_tw", Twinkle_en, 3'b100);
    chk24("ah_again_disp", number_BCD, 24'h020100);
    @(posedge clk);
    #3;
    rst_N = 1'b1;
    #1;
    chk24("arst_bcd", number_BCD, 24'h000000);
    chk3("arst_dtube", DTube_en, 3'b111);
    chk3("arst_tw", Twinkle_en, 3'b000);
    chk1("arst_alarm", ALARM, 1'b0);
    chk1("arst_hourly", HOURLY, 1'b0);
    step();
    rst_N = 1'b0;
    repeat (4) step();
    chk24("arst_no_tick_yet", number_BCD, 24'h000000);
    step();
    chk24("arst_first_tick", number_BCD, 24'h000001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
